// File: rtl/multi_strobe_gen_pkg.sv
// Shared types and constants for the multi-channel sampling-strobe generator.
package multi_strobe_gen_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_CONT  = 2'd1,
        RUN_BURST = 2'd2
    } state_t;

    localparam int   MIN_PERIOD = 2;
    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/multi_strobe_gen_phase_cmp.sv
// One strobe channel: registered one-shot when the shared counter hits this channel's phase.
module strobe_phase_cmp
    import multi_strobe_gen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] phase,
    output logic             strb
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) strb <= 1'b0;
        else          strb <= run && (cnt == phase);
    end

endmodule

// File: rtl/multi_strobe_gen.sv
// Shared period counter driving NUM_CH phase-offset strobes, continuous or burst mode.
// Optional SYNC_IN_EN adds a sync_in port that forces a counter wrap while running.
module multi_strobe_gen
    import multi_strobe_gen_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int BURST_W        = 8,
    parameter int DEFAULT_PERIOD = 5000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    start,
    input  logic [BURST_W-1:0]      burst_len,
    input  logic [CNT_W-1:0]        period,
    input  logic                    period_load,
    input  logic [NUM_CH*CNT_W-1:0] phase,
`ifdef SYNC_IN_EN
    input  logic                    sync_in,
`endif
    output logic [NUM_CH-1:0]       strb,
    output logic                    busy,
    output logic                    done,
    output logic                    period_err
);

    localparam logic [CNT_W-1:0]   MIN_P  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]   DEF_P  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [BURST_W-1:0] LAST_B = BURST_W'(1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   active_period;
    logic [CNT_W-1:0]   shadow_period;
    logic               shadow_valid;
    logic [BURST_W-1:0] burst_cnt;
    logic               done_nx;

    logic running, sync_hit, wrap, period_ok, load_ok, strb_run;

    assign running   = (state != IDLE);
`ifdef SYNC_IN_EN
    assign sync_hit  = running && sync_in;
`else
    assign sync_hit  = 1'b0;
`endif
    assign wrap      = running && ((cnt == active_period - 1'b1) || sync_hit);
    assign period_ok = (period >= MIN_P);
    assign load_ok   = period_load && period_ok;
    // The edge that stops a continuous run must not launch a strobe.
    assign strb_run  = (state == RUN_BURST) || (state == RUN_CONT && enable);

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (mode == MODE_CONT && enable)
                    state_nx = RUN_CONT;
                else if (mode == MODE_BURST && start && burst_len != '0)
                    state_nx = RUN_BURST;
            end
            RUN_CONT: begin
                if (!enable) state_nx = IDLE;
            end
            RUN_BURST: begin
                if (wrap && burst_cnt == LAST_B) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            period_err <= 1'b0;
            cnt        <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != IDLE);
            done       <= done_nx;
            period_err <= period_load && !period_ok;

            if (state == IDLE || state_nx == IDLE || wrap) cnt <= '0;
            else                                           cnt <= cnt + 1'b1;

            if (state == IDLE && state_nx == RUN_BURST) burst_cnt <= burst_len;
            else if (state == RUN_BURST && wrap)        burst_cnt <= burst_cnt - 1'b1;
        end
    end

    // A shadow still pending when a run stops is applied on the first IDLE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_period <= DEF_P;
            shadow_period <= DEF_P;
            shadow_valid  <= 1'b0;
        end else if (state == IDLE) begin
            if (load_ok) begin
                active_period <= period;
                shadow_valid  <= 1'b0;
            end else if (shadow_valid) begin
                active_period <= shadow_period;
                shadow_valid  <= 1'b0;
            end
        end else begin
            if (wrap && shadow_valid) begin
                active_period <= shadow_period;
                shadow_valid  <= 1'b0;
            end
            if (load_ok) begin
                shadow_period <= period;
                shadow_valid  <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        strobe_phase_cmp #(.CNT_W(CNT_W)) u_cmp (
            .clk     (clk),
            .reset_n (reset_n),
            .run     (strb_run),
            .cnt     (cnt),
            .phase   (phase[i*CNT_W +: CNT_W]),
            .strb    (strb[i])
        );
    end

endmodule
